// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU arbiter.
package alu_pkg;

  localparam logic [3:0] COP_ZERO  = 4'b0000;
  localparam logic [3:0] COP_ADD   = 4'b0001;
  localparam logic [3:0] COP_SUB   = 4'b0010;
  localparam logic [3:0] COP_MOVB  = 4'b0011;
  localparam logic [3:0] COP_CMPEQ = 4'b0100;
  localparam logic [3:0] COP_NOP   = 4'b0101;
  localparam logic [3:0] COP_ADD2  = 4'b0110;
  localparam logic [3:0] COP_ADD3  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Opcodes with the top bit set have no defined ALU behaviour.
  function automatic logic cop_illegal(input logic [3:0] cop);
    return cop[3];
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between two requesters and the arbiter.
interface alu_arbiter_if #(
  parameter int unsigned INPUT_WIDTH = 16
);

  logic                   req0_valid;
  logic                   req0_ready;
  logic [INPUT_WIDTH-1:0] req0_a;
  logic [INPUT_WIDTH-1:0] req0_b;
  logic [3:0]             req0_cop;

  logic                   req1_valid;
  logic                   req1_ready;
  logic [INPUT_WIDTH-1:0] req1_a;
  logic [INPUT_WIDTH-1:0] req1_b;
  logic [3:0]             req1_cop;

  logic                   resp0_valid;
  logic                   resp0_ready;
  logic                   resp1_valid;
  logic                   resp1_ready;
  logic [INPUT_WIDTH-1:0] resp_result;
  logic                   resp_ovf;
  logic                   resp_err;
  logic                   busy;

  // Requester side
  modport master (
    output req0_valid, req0_a, req0_b, req0_cop,
    output req1_valid, req1_a, req1_b, req1_cop,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_result, resp_ovf, resp_err, busy
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cop,
    input  req1_valid, req1_a, req1_b, req1_cop,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_result, resp_ovf, resp_err, busy
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU; arithmetic is done one bit wider so the top bit is carry/borrow.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 16
) (
  input  logic [INPUT_WIDTH-1:0] a,
  input  logic [INPUT_WIDTH-1:0] b,
  input  logic [3:0]             cop,
  output logic [INPUT_WIDTH-1:0] result,
  output logic                   OVF
);

  logic [INPUT_WIDTH:0] wide;

  // Opcode decode on zero-extended operands
  always_comb begin
    wide = '0;
    case (cop)
      COP_ADD, COP_ADD2, COP_ADD3: wide = {1'b0, a} + {1'b0, b};
      COP_SUB:                     wide = {1'b0, a} - {1'b0, b};
      COP_MOVB:                    wide = {1'b0, b};
      COP_CMPEQ:                   wide = {{INPUT_WIDTH{1'b0}}, (a == b)};
      default:                     wide = '0;
    endcase
  end

  assign result = wide[INPUT_WIDTH-1:0];
  assign OVF    = wide[INPUT_WIDTH];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-port arbiter and IDLE/EXEC/RESP sequencer around a shared ALU.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  state_e                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] a_q, b_q;
  logic [3:0]             cop_q;
  logic                   owner_q;
  logic                   last_grant_q;
  logic [INPUT_WIDTH-1:0] result_q;
  logic                   ovf_q, err_q;

  logic                   grant;
  logic                   grant_valid;
  logic                   idle_ok;
  logic                   accept;
  logic                   resp_hs;
  logic [INPUT_WIDTH-1:0] alu_result;
  logic                   alu_ovf;

  // Pick a requester: a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    grant       = 1'b0;
    grant_valid = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant       = ~last_grant_q;
      grant_valid = 1'b1;
    end else if (bus.req0_valid) begin
      grant       = 1'b0;
      grant_valid = 1'b1;
    end else if (bus.req1_valid) begin
      grant       = 1'b1;
      grant_valid = 1'b1;
    end
  end

  // Ready is gated by rst_n so nothing is accepted while reset is held
  assign idle_ok        = rst_n && (state_q == IDLE);
  assign bus.req0_ready = idle_ok && grant_valid && !grant;
  assign bus.req1_ready = idle_ok && grant_valid && grant;
  assign accept         = bus.req0_ready || bus.req1_ready;

  // Only the owner's ready completes a response
  assign resp_hs = owner_q ? bus.resp1_ready : bus.resp0_ready;

  alu #(
    .INPUT_WIDTH(INPUT_WIDTH)
  ) u_alu (
    .a      (a_q),
    .b      (b_q),
    .cop    (cop_q),
    .result (alu_result),
    .OVF    (alu_ovf)
  );

  // Next-state logic for the sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch and response capture with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      cop_q        <= COP_ZERO;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        owner_q      <= grant;
        last_grant_q <= grant;
        a_q          <= grant ? bus.req1_a   : bus.req0_a;
        b_q          <= grant ? bus.req1_b   : bus.req0_b;
        cop_q        <= grant ? bus.req1_cop : bus.req0_cop;
      end
      if (state_q == EXEC) begin
        if (cop_illegal(cop_q)) begin
          result_q <= '0;
          ovf_q    <= 1'b0;
          err_q    <= 1'b1;
        end else begin
          result_q <= alu_result;
          ovf_q    <= alu_ovf;
          err_q    <= 1'b0;
        end
      end
    end
  end

  assign bus.resp0_valid = rst_n && (state_q == RESP) && !owner_q;
  assign bus.resp1_valid = rst_n && (state_q == RESP) && owner_q;
  assign bus.busy        = rst_n && (state_q != IDLE);
  assign bus.resp_result = result_q;
  assign bus.resp_ovf    = ovf_q;
  assign bus.resp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: handshake timing, arithmetic, arbitration, backpressure, reset.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_arbiter_if #(.INPUT_WIDTH(16)) bus ();

  alu_arbiter #(
    .INPUT_WIDTH(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] cop);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cop = cop;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cop = cop;
    end
  endtask

  function automatic logic ready_of(input int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rvalid_of(input int p);
    return (p == 0) ? bus.resp0_valid : bus.resp1_valid;
  endfunction

  // Issue one op on port p with both resp_ready high; returns observed response and latency
  task automatic run_op(input int p, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] cop, output logic [15:0] res, output logic ovf,
                        output logic err, output logic other_v, output int lat);
    bit acc;
    bit got;
    acc = 0; got = 0; lat = -1;
    res = '0; ovf = 1'b0; err = 1'b0; other_v = 1'b0;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    set_req(p, 1'b1, a, b, cop);
    for (int i = 0; i < 10 && !acc; i++) begin
      #1;
      if (ready_of(p)) acc = 1;
      step();
    end
    set_req(p, 1'b0, a, b, cop);
    if (acc) begin
      for (int j = 0; j < 10 && !got; j++) begin
        #1;
        if (rvalid_of(p)) begin
          got     = 1;
          lat     = j + 1;
          res     = bus.resp_result;
          ovf     = bus.resp_ovf;
          err     = bus.resp_err;
          other_v = rvalid_of(1 - p);
        end
        step();
      end
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_req(0, 1'b1, 16'h0001, 16'h0001, COP_ADD);
    set_req(1, 1'b1, 16'h0001, 16'h0001, COP_ADD);
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    step();
    step();
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if ({bus.resp0_valid, bus.resp1_valid, bus.busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_valid_busy: got %b want 000", {bus.resp0_valid, bus.resp1_valid, bus.busy});
    end
    checks++;
    if ({bus.resp_result, bus.resp_ovf, bus.resp_err} !== 18'h0) begin
      failures++;
      $display("FAIL reset_resp_regs: got %h want 0", {bus.resp_result, bus.resp_ovf, bus.resp_err});
    end
    set_req(0, 1'b0, 16'h0, 16'h0, COP_ZERO);
    set_req(1, 1'b0, 16'h0, 16'h0, COP_ZERO);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_add;
    set_req(0, 1'b1, 16'h0003, 16'h0005, COP_ADD);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      failures++; $display("FAIL add_accept_ready: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    step();
    set_req(0, 1'b0, 16'h0, 16'h0, COP_ZERO);
    #1;
    checks++;
    if ({bus.busy, bus.resp0_valid} !== 2'b10) begin
      failures++; $display("FAIL add_exec: got busy,valid=%b want 10", {bus.busy, bus.resp0_valid});
    end
    step();
    #1;
    checks++;
    if ({bus.resp0_valid, bus.resp1_valid} !== 2'b10) begin
      failures++;
      $display("FAIL add_resp_valid: got %b want 10", {bus.resp0_valid, bus.resp1_valid});
    end
    checks++;
    if (bus.resp_result !== 16'h0008 || bus.resp_ovf !== 1'b0 || bus.resp_err !== 1'b0) begin
      failures++;
      $display("FAIL add_resp_data: got %h/%b/%b want 0008/0/0",
               bus.resp_result, bus.resp_ovf, bus.resp_err);
    end
    step();
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL add_back_idle: got busy %b want 0", bus.busy);
    end
    step();
  endtask

  task automatic test_carry_borrow;
    logic [15:0] res;
    logic ovf, err, ov;
    int lat;
    run_op(0, 16'hFFFF, 16'h0001, COP_ADD, res, ovf, err, ov, lat);
    checks++;
    if (lat !== 2 || res !== 16'h0000 || ovf !== 1'b1 || err !== 1'b0 || ov !== 1'b0) begin
      failures++;
      $display("FAIL add_carry: got lat=%0d %h/%b/%b/%b want lat=2 0000/1/0/0", lat, res, ovf, err, ov);
    end
    run_op(1, 16'h0003, 16'h0005, COP_SUB, res, ovf, err, ov, lat);
    checks++;
    if (lat !== 2 || res !== 16'hFFFE || ovf !== 1'b1 || err !== 1'b0 || ov !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow: got lat=%0d %h/%b/%b/%b want lat=2 fffe/1/0/0", lat, res, ovf, err, ov);
    end
    run_op(0, 16'h1234, 16'h1234, COP_CMPEQ, res, ovf, err, ov, lat);
    checks++;
    if (lat !== 2 || res !== 16'h0001 || ovf !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL cmpeq_equal: got lat=%0d %h/%b/%b want lat=2 0001/0/0", lat, res, ovf, err);
    end
    run_op(1, 16'h1234, 16'hABCD, COP_MOVB, res, ovf, err, ov, lat);
    checks++;
    if (lat !== 2 || res !== 16'hABCD || ovf !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL movb: got lat=%0d %h/%b/%b want lat=2 abcd/0/0", lat, res, ovf, err);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    set_req(0, 1'b1, 16'h0001, 16'h0002, COP_ADD);
    set_req(1, 1'b1, 16'h0000, 16'h0055, COP_MOVB);
    for (int k = 0; k < 4; k++) begin
      logic [1:0]  exp_rdy;
      logic [15:0] exp_res;
      exp_rdy = (k % 2 == 0) ? 2'b10 : 2'b01;
      exp_res = (k % 2 == 0) ? 16'h0003 : 16'h0055;
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== exp_rdy) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got %b want %b", k, {bus.req0_ready, bus.req1_ready}, exp_rdy);
      end
      step();
      step();
      #1;
      checks++;
      if ({bus.resp0_valid, bus.resp1_valid} !== exp_rdy) begin
        failures++;
        $display("FAIL rr_owner[%0d]: got %b want %b", k, {bus.resp0_valid, bus.resp1_valid}, exp_rdy);
      end
      checks++;
      if (bus.resp_result !== exp_res) begin
        failures++; $display("FAIL rr_result[%0d]: got %h want %h", k, bus.resp_result, exp_res);
      end
      step();
    end
    set_req(0, 1'b0, 16'h0, 16'h0, COP_ZERO);
    set_req(1, 1'b0, 16'h0, 16'h0, COP_ZERO);
  endtask

  task automatic test_backpressure;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b0;
    set_req(1, 1'b1, 16'h0010, 16'h0020, COP_ADD);
    #1;
    step();
    set_req(1, 1'b0, 16'h0, 16'h0, COP_ZERO);
    step();
    set_req(0, 1'b1, 16'h0001, 16'h0001, COP_ADD);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({bus.resp1_valid, bus.resp0_valid, bus.busy, bus.req0_ready} !== 4'b1010 ||
          bus.resp_result !== 16'h0030) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v1,v0,busy,rdy0=%b res=%h want 1010 res=0030", c,
                 {bus.resp1_valid, bus.resp0_valid, bus.busy, bus.req0_ready}, bus.resp_result);
      end
      step();
    end
    bus.resp1_ready = 1'b1;
    #1;
    checks++;
    if (bus.resp1_valid !== 1'b1) begin
      failures++; $display("FAIL bp_ready_rise: got resp1_valid %b want 1", bus.resp1_valid);
    end
    step();
    #1;
    checks++;
    if ({bus.busy, bus.resp1_valid, bus.req0_ready} !== 3'b001) begin
      failures++;
      $display("FAIL bp_complete: got busy,v1,rdy0=%b want 001", {bus.busy, bus.resp1_valid, bus.req0_ready});
    end
    set_req(0, 1'b0, 16'h0, 16'h0, COP_ZERO);
    step();
  endtask

  task automatic test_illegal;
    logic [15:0] res;
    logic ovf, err, ov;
    int lat;
    run_op(0, 16'h1234, 16'h5678, 4'b1010, res, ovf, err, ov, lat);
    checks++;
    if (lat !== 2 || res !== 16'h0000 || ovf !== 1'b0 || err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_cop: got lat=%0d %h/%b/%b want lat=2 0000/0/1", lat, res, ovf, err);
    end
    checks++;
    if ($isunknown({res, ovf, err, ov})) begin
      failures++; $display("FAIL illegal_no_x: got %b want no X", {res, ovf, err, ov});
    end
  endtask

  task automatic test_reset_mid_exec;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    set_req(0, 1'b1, 16'h0007, 16'h0008, COP_ADD);
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      failures++; $display("FAIL mid_accept: got req0_ready %b want 1", bus.req0_ready);
    end
    step();
    set_req(0, 1'b0, 16'h0, 16'h0, COP_ZERO);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL mid_exec_busy: got %b want 1", bus.busy);
    end
    rst_n = 1'b0;
    step();
    set_req(0, 1'b1, 16'h0001, 16'h0001, COP_ADD);
    set_req(1, 1'b1, 16'h0001, 16'h0001, COP_ADD);
    #1;
    checks++;
    if ({bus.busy, bus.resp0_valid, bus.resp1_valid, bus.req0_ready, bus.req1_ready} !== 5'b0 ||
        {bus.resp_result, bus.resp_ovf, bus.resp_err} !== 18'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got flags=%b resp=%h want 0/0",
               {bus.busy, bus.resp0_valid, bus.resp1_valid, bus.req0_ready, bus.req1_ready},
               {bus.resp_result, bus.resp_ovf, bus.resp_err});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL mid_tie_after_reset: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    set_req(0, 1'b0, 16'h0, 16'h0, COP_ZERO);
    set_req(1, 1'b0, 16'h0, 16'h0, COP_ZERO);
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      checks++;
      if ({bus.busy, bus.resp0_valid, bus.resp1_valid} !== 3'b000) begin
        failures++;
        $display("FAIL mid_no_resp[%0d]: got %b want 000", c,
                 {bus.busy, bus.resp0_valid, bus.resp1_valid});
      end
    end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    set_req(0, 1'b0, 16'h0, 16'h0, COP_ZERO);
    set_req(1, 1'b0, 16'h0, 16'h0, COP_ZERO);
    test_reset();
    test_single_add();
    test_carry_borrow();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and two-port arbiter that shares the single combinational `alu` between two requesters (e.g. the decode stage and a secondary issue port). It accepts one operation at a time over a valid/ready handshake, registers the operands, runs them through the ALU for one cycle, and returns result, overflow and error status to the owning requester over a second valid/ready handshake. Arbitration is round-robin.

## Interface
- `INPUT_WIDTH`, 16, operand/result width; passed to the `alu` instance.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req0_valid`, `req1_valid` input 1: request N presents an operation.
- `req0_ready`, `req1_ready` output 1: request N is accepted this cycle.
- `req0_a`, `req1_a` input INPUT_WIDTH: operand A.
- `req0_b`, `req1_b` input INPUT_WIDTH: operand B.
- `req0_cop`, `req1_cop` input 4: ALU opcode.
- `resp0_valid`, `resp1_valid` output 1: response for requester N is present.
- `resp0_ready`, `resp1_ready` input 1: requester N consumes the response.
- `resp_result` output INPUT_WIDTH: shared result bus; qualified by `respN_valid`.
- `resp_ovf` output 1: bit INPUT_WIDTH of the (INPUT_WIDTH+1)-bit ALU result.
- `resp_err` output 1: opcode was illegal (`cop[3]==1`).
- `busy` output 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: `reqN_ready` is asserted combinationally for exactly one requester, the granted one, and only if its `reqN_valid` is high. Grant rules:
  - If only one requester is valid, it is granted.
  - If both are valid, the one not equal to `last_grant` is granted.
- On handshake (`valid && ready`): latch a, b, cop and owner ID; set `last_grant` to owner; go to EXEC.
- EXEC (one cycle): the ALU is driven from the latched operands, and the result is captured into the response registers.
  - If `cop[3]==0`: `resp_result = alu.result`, `resp_ovf = alu.OVF`, `resp_err = 0`.
  - If `cop[3]==1`: `resp_result = 0`, `resp_ovf = 0`, `resp_err = 1`. The ALU's X output is never sampled.
  - Go to RESP.
- RESP: `resp<owner>_valid = 1`; the other response valid stays 0. Result, ovf and err are held stable. When `resp<owner>_ready` is 1, return to IDLE. No request is accepted in RESP.
- Arithmetic, performed in INPUT_WIDTH+1 bits with zero-extended operands:
  - ADD 0001/0110/0111: `ovf` is the carry-out.
  - SUB 0010: `ovf` is 1 when A < B (borrow).
  - 0000/0101: result 0, ovf 0.
  - MOVB 0011: result B, ovf 0.
  - CMPEQ 0100: result 1 or 0, ovf 0.
- `busy = (state != IDLE)`.

## Timing
- Reset (`rst_n == 0` at a rising edge):
  - state goes to IDLE; `last_grant` is set to 1, so requester 0 wins the first tie.
  - The response registers go to result 0, ovf 0, err 0.
  - `respN_valid`, `busy` and `reqN_ready` are all 0 while `rst_n` is low (ready is gated by `rst_n`).
- Latency: request accepted at edge T, EXEC in cycle T+1, `respN_valid` high from cycle T+2.
- Minimum occupancy is 3 cycles per operation: accept, EXEC, RESP with ready already high.
- Back-to-back operations: the next request can be accepted in the IDLE cycle following the response handshake.
- Response backpressure: RESP holds indefinitely while `respN_ready` is 0, and all outputs remain stable.
- Request inputs are ignored outside IDLE; a requester must hold `valid` and its operands until it sees `ready`.
- The non-owner's `respN_ready` is ignored.
- Reset mid-operation (EXEC or RESP): the in-flight operation is dropped and no response is issued.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode localparams: COP_ZERO=4'b0000, COP_ADD=4'b0001, COP_SUB=4'b0010, COP_MOVB=4'b0011, COP_CMPEQ=4'b0100, COP_NOP=4'b0101, COP_ADD2=4'b0110, COP_ADD3=4'b0111;
  - the FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- The only sub-module is the existing `alu`, instantiated once with `INPUT_WIDTH` passed through. Arbitration and the FSM stay in this module.

## Test plan
- Reset, then a single ADD on port 0 with A=16'h0003, B=16'h0005: `req0_ready` is high in the accept cycle; two cycles later `resp0_valid=1`, result 16'h0008, ovf 0, err 0, and `resp1_valid` stays 0.
- Carry and borrow:
  - ADD 16'hFFFF + 16'h0001 returns result 16'h0000, ovf 1.
  - SUB 16'h0003 − 16'h0005 returns result 16'hFFFE, ovf 1.
  - CMPEQ 16'h1234, 16'h1234 returns result 1.
- Both ports valid for 4 consecutive operations: grants go 0, 1, 0, 1, and each response appears only on the owning port.
- Backpressure: hold `resp1_ready=0` for 5 cycles in RESP. Result, `resp1_valid` and `busy` stay constant, `req0` is not accepted, and the block completes one cycle after ready rises.
- Illegal opcode 4'b1010 returns `resp_err=1`, result 16'h0000, ovf 0, with no X on any output.
- Assert `rst_n=0` during EXEC: the next cycle is IDLE with all outputs at their reset values and no response; after release, requester 0 wins a tie.
